// File: rtl/ctrl_unit.sv
// ctrl_unit: four-state instruction sequencer with PC.
// Latches an instruction, decodes it and strobes the write-back.
module ctrl_unit #(
  parameter int         PC_STEP  = 4,
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] INSTR,
  input  logic        INSTR_VALID,
  output logic        INSTR_READY,
  output logic [7:0]  PC,
  output logic [2:0]  OUT1ADDR,
  output logic [2:0]  OUT2ADDR,
  output logic [2:0]  INADDR,
  output logic [7:0]  IMM,
  output logic [2:0]  ALUOP,
  output logic        IMM_SEL,
  output logic        NEG_SEL,
  output logic        WRITE_EN,
  output logic        ILLEGAL
);

  localparam logic [7:0] STEP = 8'(PC_STEP);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    WB     = 2'd3
  } state_t;

  state_t     state;
  logic [7:0] ir_op;
  logic [2:0] ir_dst;
  logic [7:0] ir_imm;
  logic [2:0] ir_s2;

  // Instruction bits outside the defined fields carry no meaning.
  logic unused_instr;
  assign unused_instr = ^{INSTR[23:19], INSTR[7:3]};

  logic       d_legal;
  logic       d_use1;
  logic       d_use2;
  logic       d_imm_sel;
  logic       d_neg_sel;
  logic [2:0] d_aluop;

  // Opcode decode of the latched instruction.
  always_comb begin
    d_legal   = 1'b1;
    d_use1    = 1'b0;
    d_use2    = 1'b0;
    d_imm_sel = 1'b0;
    d_neg_sel = 1'b0;
    d_aluop   = 3'b000;
    unique case (1'b1)
      (ir_op == 8'h00): d_imm_sel = 1'b1;
      (ir_op == 8'h01): d_use2 = 1'b1;
      (ir_op == 8'h02): begin
        d_use1  = 1'b1;
        d_use2  = 1'b1;
        d_aluop = 3'b001;
      end
      (ir_op == 8'h03): begin
        d_use1    = 1'b1;
        d_use2    = 1'b1;
        d_aluop   = 3'b001;
        d_neg_sel = 1'b1;
      end
      (ir_op == 8'h04): begin
        d_use1  = 1'b1;
        d_use2  = 1'b1;
        d_aluop = 3'b010;
      end
      (ir_op == 8'h05): begin
        d_use1  = 1'b1;
        d_use2  = 1'b1;
        d_aluop = 3'b011;
      end
      default: d_legal = 1'b0;
    endcase
  end

  // Sequencer with registered outputs; an illegal opcode leaves
  // the previous decode fields untouched.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state       <= IDLE;
      ir_op       <= '0;
      ir_dst      <= '0;
      ir_imm      <= '0;
      ir_s2       <= '0;
      INSTR_READY <= 1'b1;
      PC          <= RESET_PC;
      OUT1ADDR    <= '0;
      OUT2ADDR    <= '0;
      INADDR      <= '0;
      IMM         <= '0;
      ALUOP       <= '0;
      IMM_SEL     <= 1'b0;
      NEG_SEL     <= 1'b0;
      WRITE_EN    <= 1'b0;
      ILLEGAL     <= 1'b0;
    end else begin
      WRITE_EN <= 1'b0;
      ILLEGAL  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (INSTR_VALID) begin
            ir_op       <= INSTR[31:24];
            ir_dst      <= INSTR[18:16];
            ir_imm      <= INSTR[15:8];
            ir_s2       <= INSTR[2:0];
            INSTR_READY <= 1'b0;
            state       <= DECODE;
          end
        end
        DECODE: begin
          if (d_legal) begin
            INADDR   <= ir_dst;
            IMM      <= ir_imm;
            OUT1ADDR <= d_use1 ? ir_imm[2:0] : 3'b000;
            OUT2ADDR <= d_use2 ? ir_s2 : 3'b000;
            ALUOP    <= d_aluop;
            IMM_SEL  <= d_imm_sel;
            NEG_SEL  <= d_neg_sel;
            state    <= EXEC;
          end else begin
            ILLEGAL     <= 1'b1;
            PC          <= PC + STEP;
            INSTR_READY <= 1'b1;
            state       <= IDLE;
          end
        end
        EXEC: state <= WB;
        WB: begin
          WRITE_EN    <= 1'b1;
          PC          <= PC + STEP;
          INSTR_READY <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ctrl_unit.sv
// tb_ctrl_unit: timeline model plus directed checks
// for the ctrl_unit sequencer.
module tb_ctrl_unit;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [31:0] INSTR = '0;
  logic        INSTR_VALID = 1'b0;
  logic        INSTR_READY;
  logic [7:0]  PC;
  logic [2:0]  OUT1ADDR, OUT2ADDR, INADDR, ALUOP;
  logic [7:0]  IMM;
  logic        IMM_SEL, NEG_SEL, WRITE_EN, ILLEGAL;

  int n_chk = 0;
  int n_fail = 0;

  ctrl_unit #(.PC_STEP(4), .RESET_PC(8'h00)) dut (
    .CLK(CLK), .RESET(RESET), .INSTR(INSTR),
    .INSTR_VALID(INSTR_VALID), .INSTR_READY(INSTR_READY),
    .PC(PC), .OUT1ADDR(OUT1ADDR), .OUT2ADDR(OUT2ADDR),
    .INADDR(INADDR), .IMM(IMM), .ALUOP(ALUOP),
    .IMM_SEL(IMM_SEL), .NEG_SEL(NEG_SEL),
    .WRITE_EN(WRITE_EN), .ILLEGAL(ILLEGAL)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Timeline model: an accept at edge e schedules its effects
  // at later edge numbers.
  int         e = 0;
  int         rdy_at = 0, we_at = -1, ill_at = -1;
  int         pc_at = -1, dec_at = -1;
  logic [31:0] pend = '0;
  logic        m_rdy = 1'b1, m_we = 1'b0, m_ill = 1'b0;
  logic [7:0]  m_pc = '0, m_imm = '0;
  logic [2:0]  m_o1 = '0, m_o2 = '0, m_in = '0, m_alu = '0;
  logic        m_isel = 1'b0, m_nsel = 1'b0;

  always @(posedge CLK) begin
    if (RESET) begin
      e = 0; rdy_at = 0; we_at = -1; ill_at = -1;
      pc_at = -1; dec_at = -1;
      m_rdy = 1; m_we = 0; m_ill = 0; m_pc = 0; m_imm = 0;
      m_o1 = 0; m_o2 = 0; m_in = 0; m_alu = 0;
      m_isel = 0; m_nsel = 0;
    end else begin
      e++;
      if (m_rdy && INSTR_VALID) begin
        pend = INSTR;
        if (INSTR[31:24] <= 8'h05) begin
          dec_at = e + 1; we_at = e + 3;
          pc_at = e + 3; rdy_at = e + 3;
        end else begin
          ill_at = e + 1; pc_at = e + 1; rdy_at = e + 1;
        end
      end
      m_rdy = (e >= rdy_at);
      m_we  = (e == we_at);
      m_ill = (e == ill_at);
      if (e == pc_at) m_pc = m_pc + 8'd4;
      if (e == dec_at) begin
        m_in = pend[18:16]; m_imm = pend[15:8];
        m_o1 = 0; m_o2 = 0; m_alu = 0;
        m_isel = 0; m_nsel = 0;
        case (pend[31:24])
          8'h00: m_isel = 1;
          8'h01: m_o2 = pend[2:0];
          8'h02: begin m_o1 = pend[10:8]; m_o2 = pend[2:0]; m_alu = 1; end
          8'h03: begin m_o1 = pend[10:8]; m_o2 = pend[2:0]; m_alu = 1; m_nsel = 1; end
          8'h04: begin m_o1 = pend[10:8]; m_o2 = pend[2:0]; m_alu = 2; end
          default: begin m_o1 = pend[10:8]; m_o2 = pend[2:0]; m_alu = 3; end
        endcase
      end
    end
  end

  // Per-cycle comparison against the model.
  always begin
    @(posedge CLK);
    #1;
    chk("cmp_ready", 32'(INSTR_READY), 32'(m_rdy));
    chk("cmp_pc", 32'(PC), 32'(m_pc));
    chk("cmp_we", 32'(WRITE_EN), 32'(m_we));
    chk("cmp_ill", 32'(ILLEGAL), 32'(m_ill));
    chk("cmp_out1", 32'(OUT1ADDR), 32'(m_o1));
    chk("cmp_out2", 32'(OUT2ADDR), 32'(m_o2));
    chk("cmp_inaddr", 32'(INADDR), 32'(m_in));
    chk("cmp_imm", 32'(IMM), 32'(m_imm));
    chk("cmp_aluop", 32'(ALUOP), 32'(m_alu));
    chk("cmp_immsel", 32'(IMM_SEL), 32'(m_isel));
    chk("cmp_negsel", 32'(NEG_SEL), 32'(m_nsel));
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic accept(input logic [31:0] ins);
    chk("accept_ready", 32'(INSTR_READY), 32'd1);
    INSTR = ins;
    INSTR_VALID = 1'b1;
    tick();
    INSTR_VALID = 1'b0;
    INSTR = $urandom;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: no finish by %0t", $time);
    $fatal(1);
  end

  initial begin
    tick();
    tick();
    chk("rst_ready", 32'(INSTR_READY), 32'd1);
    chk("rst_pc", 32'(PC), 32'h00);
    chk("rst_we", 32'(WRITE_EN), 32'd0);
    chk("rst_aluop", 32'(ALUOP), 32'd0);
    RESET = 1'b0;
    tick();

    // loadi r2, 0x5A
    accept(32'h00025A00);
    chk("ldi_busy", 32'(INSTR_READY), 32'd0);
    tick();
    chk("ldi_inaddr", 32'(INADDR), 32'd2);
    chk("ldi_imm", 32'(IMM), 32'h5A);
    chk("ldi_immsel", 32'(IMM_SEL), 32'd1);
    tick();
    chk("ldi_we_n2", 32'(WRITE_EN), 32'd0);
    tick();
    chk("ldi_we_n3", 32'(WRITE_EN), 32'd1);
    chk("ldi_pc", 32'(PC), 32'h04);

    // sub r4, r1, r2 with junk valid while busy
    accept(32'h03040102);
    chk("sub_we_n1", 32'(WRITE_EN), 32'd0);
    INSTR = 32'h07000000;
    INSTR_VALID = 1'b1;
    tick();
    chk("sub_out1", 32'(OUT1ADDR), 32'd1);
    chk("sub_out2", 32'(OUT2ADDR), 32'd2);
    chk("sub_inaddr", 32'(INADDR), 32'd4);
    chk("sub_aluop", 32'(ALUOP), 32'b001);
    chk("sub_negsel", 32'(NEG_SEL), 32'd1);
    tick();
    INSTR_VALID = 1'b0;
    tick();
    chk("sub_we", 32'(WRITE_EN), 32'd1);
    chk("sub_pc", 32'(PC), 32'h08);
    tick();
    chk("sub_we_once", 32'(WRITE_EN), 32'd0);

    // illegal opcode 0x07
    accept(32'h07123456);
    tick();
    chk("ill_pulse", 32'(ILLEGAL), 32'd1);
    chk("ill_ready", 32'(INSTR_READY), 32'd1);
    chk("ill_pc", 32'(PC), 32'h0C);
    chk("ill_we", 32'(WRITE_EN), 32'd0);
    tick();
    chk("ill_once", 32'(ILLEGAL), 32'd0);

    // mov / and / or checked by the model
    accept(32'h01050003);
    repeat (3) tick();
    accept(32'h04060507);
    repeat (3) tick();
    accept(32'h05070604);
    repeat (3) tick();

    // back-to-back adds with valid held high
    INSTR = 32'h02010203;
    INSTR_VALID = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk("b2b_ready", 32'(INSTR_READY), 32'(k % 4 == 0));
      chk("b2b_we", 32'(WRITE_EN), 32'(k % 4 == 0));
      chk("b2b_pc", 32'(PC), 32'h18 + 32'(4 * (k / 4)));
    end
    INSTR_VALID = 1'b0;
    tick();

    // 64 instructions from reset wrap PC to 00
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    INSTR = 32'h00015500;
    INSTR_VALID = 1'b1;
    for (int k = 1; k <= 252; k++) tick();
    chk("wrap_pc_fc", 32'(PC), 32'hFC);
    repeat (4) tick();
    chk("wrap_pc_00", 32'(PC), 32'h00);
    INSTR_VALID = 1'b0;
    tick();

    // reset during EXEC of an add
    accept(32'h02030102);
    tick();
    #3;
    RESET = 1'b1;
    #1;
    chk("rexec_we", 32'(WRITE_EN), 32'd0);
    chk("rexec_pc", 32'(PC), 32'h00);
    chk("rexec_ready", 32'(INSTR_READY), 32'd1);
    tick();
    RESET = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("rexec_no_we", 32'(WRITE_EN), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ctrl_unit.md
CTRL_UNIT -- requirements
Module: ctrl_unit

Interface
REQ-001 The block SHALL have parameter PC_STEP, default 4, giving the PC increment per retired instruction.
REQ-002 The block SHALL have parameter RESET_PC, default 8'h00, giving the PC value after reset.
REQ-003 The block SHALL have port CLK, input, 1 bit, system clock; all state updates on posedge.
REQ-004 The block SHALL have port RESET, input, 1 bit, asynchronous, active-high reset.
REQ-005 The block SHALL have port INSTR, input, 32 bits: opcode [31:24], dest [18:16], src1/imm [15:8], src2 [2:0].
REQ-006 The block SHALL have port INSTR_VALID, input, 1 bit, high when INSTR holds an instruction.
REQ-007 The block SHALL have port INSTR_READY, output, 1 bit, high when the block can accept an instruction.
REQ-008 The block SHALL have port PC, output, 8 bits, address of the next instruction to fetch.
REQ-009 The block SHALL have ports OUT1ADDR and OUT2ADDR, outputs, 3 bits each, register-file read addresses.
REQ-010 The block SHALL have port INADDR, output, 3 bits, register-file write address.
REQ-011 The block SHALL have port IMM, output, 8 bits, immediate operand.
REQ-012 The block SHALL have port ALUOP, output, 3 bits: 000 forward, 001 add, 010 and, 011 or.
REQ-013 The block SHALL have ports IMM_SEL and NEG_SEL, outputs, 1 bit each: operand-2 mux selects IMM; operand 2 is two's-complement negated.
REQ-014 The block SHALL have port WRITE_EN, output, 1 bit, register-file write strobe.
REQ-015 The block SHALL have port ILLEGAL, output, 1 bit, one-cycle pulse on an undefined opcode.

Function
REQ-016 The FSM SHALL have states IDLE, DECODE, EXEC, WB, encoded in 2 bits.
REQ-017 In IDLE, INSTR_READY SHALL be 1 and INSTR_READY SHALL be 0 in every other state.
REQ-018 When INSTR_VALID=1 in IDLE, INSTR SHALL be latched into an internal IR and the FSM SHALL move to DECODE; with INSTR_VALID=0 it stays in IDLE.
REQ-019 In DECODE, OUT1ADDR, OUT2ADDR, INADDR, IMM, ALUOP, IMM_SEL and NEG_SEL SHALL be registered from IR, then held stable until the next accept.
REQ-020 Decode: 0x00 loadi -> ALUOP=000, IMM_SEL=1; 0x01 mov -> 000, IMM_SEL=0; 0x02 add -> 001; 0x03 sub -> 001, NEG_SEL=1; 0x04 and -> 010; 0x05 or -> 011.
REQ-021 For opcodes 0x02–0x05, OUT1ADDR SHALL be IR[10:8] and OUT2ADDR SHALL be IR[2:0].
REQ-022 For mov, OUT2ADDR SHALL be IR[2:0]; IMM SHALL always be IR[15:8].
REQ-023 Opcodes 0x06–0xFF SHALL, in DECODE, pulse ILLEGAL for one cycle and return to IDLE, skipping EXEC and WB, with no WRITE_EN.
REQ-024 After an illegal opcode, PC SHALL still advance by PC_STEP on the DECODE->IDLE transition.
REQ-025 EXEC SHALL last exactly one cycle to allow register-file read and ALU settle, then go to WB.
REQ-026 In WB, WRITE_EN SHALL be 1 for exactly one cycle, PC SHALL advance by PC_STEP modulo 256, and the FSM SHALL return to IDLE.
REQ-027 For a legal instruction accepted at edge N, WRITE_EN SHALL be high for the cycle following edge N+3, and the next accept SHALL occur no earlier than edge N+4.
REQ-028 Throughput SHALL be one legal instruction per 4 cycles and one illegal instruction per 2 cycles.
REQ-029 PC SHALL wrap from 8'hFC to 8'h00 with PC_STEP=4, with no flag.
REQ-030 INSTR and INSTR_VALID SHALL be ignored outside IDLE.

Reset
REQ-031 While RESET=1, the FSM SHALL be IDLE and PC SHALL equal RESET_PC.
REQ-032 While RESET=1, all address, IMM, ALUOP, select, WRITE_EN and ILLEGAL outputs SHALL be 0, and INSTR_READY SHALL be 1.
REQ-033 Reset asserted in any state, including WB, SHALL immediately deassert WRITE_EN, abort the instruction, and leave PC at RESET_PC.

Verification
REQ-034 loadi 0x00_02_5A_00 accepted -> DECODE: INADDR=2, IMM=5A, IMM_SEL=1; WRITE_EN high 3 cycles after accept; PC 00->04.
REQ-035 sub 0x03_04_01_02 -> OUT1ADDR=1, OUT2ADDR=2, INADDR=4, ALUOP=001, NEG_SEL=1, a single WRITE_EN pulse.
REQ-036 Opcode 0x07 -> ILLEGAL pulse in DECODE, no WRITE_EN, INSTR_READY back after 2 cycles, PC+4.
REQ-037 INSTR_VALID held high with back-to-back add instructions -> accepts spaced exactly 4 cycles, PC increments once each.
REQ-038 64 retired instructions from PC=00 -> PC returns to 00.
REQ-039 RESET pulsed during EXEC of an add -> no WRITE_EN, PC=00, INSTR_READY=1 immediately.
